// File: rtl/coherence_bus_arbiter_if.sv
// Cache/RAM-side signal bundle for coherence_bus_arbiter: per-core I/D cache
// handshakes, snoop lines and the single RAM port.
interface coherence_bus_arbiter_if #(
  parameter int CPUS   = 4,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]              iREN, iwait;
  logic [CPUS-1:0][WORD_W-1:0]  iaddr, iload;
  logic [CPUS-1:0]              dREN, dWEN, dwait;
  logic [CPUS-1:0][WORD_W-1:0]  daddr, dstore, dload;
  logic [CPUS-1:0]              cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr;
  logic                         ramREN, ramWEN;
  logic [WORD_W-1:0]            ramaddr, ramstore, ramload;
  logic [1:0]                   ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// N-core snooping bus controller: round-robin grant (writeback > snoop > ifetch),
// snoop broadcast, cache-to-cache transfer. Optional counters: COHERENCE_STATS_EN.
module coherence_bus_arbiter #(
  parameter int CPUS      = 4,
  parameter int BLK_WORDS = 2,
  parameter int WORD_W    = 32
) (
  input  logic CLK,
  input  logic nRST,
  coherence_bus_arbiter_if.slave bus
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0] c2c_cnt,
  output logic [31:0] ramld_cnt,
  output logic [31:0] wb_cnt
`endif
);
  localparam int IW = $clog2(CPUS);
  localparam int CW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, WB, IFETCH, SNOOP, C2C, RAMLD} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     gnt, gnt_n, resp, resp_n, rr_d, rr_d_n, rr_i, rr_i_n;
  logic [CW-1:0]     wcnt, wcnt_n;
  logic              access, last_word, all_resp, hit;
  logic [IW-1:0]     resp_sel;
  logic [WORD_W-1:0] req_addr;

  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    pick = ptr;
    for (int k = CPUS - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % CPUS);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] p);
    return (p == IW'(CPUS - 1)) ? '0 : p + IW'(1);
  endfunction

  assign access    = (bus.ramstate == RAM_ACCESS);
  assign last_word = (wcnt == CW'(BLK_WORDS - 1));
  assign req_addr  = bus.daddr[gnt];

  // Snoop completion: every other core has answered; lowest-index M holder supplies data.
  always_comb begin
    all_resp = 1'b1;
    hit      = 1'b0;
    resp_sel = '0;
    for (int j = 0; j < CPUS; j++) begin
      if (IW'(j) != gnt) begin
        if (!bus.cctrans[IW'(j)]) all_resp = 1'b0;
        if (bus.ccwrite[IW'(j)] && !hit) begin
          hit      = 1'b1;
          resp_sel = IW'(j);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      resp  <= '0;
      rr_d  <= '0;
      rr_i  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      resp  <= resp_n;
      rr_d  <= rr_d_n;
      rr_i  <= rr_i_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n          = state;
    gnt_n            = gnt;
    resp_n           = resp;
    rr_d_n           = rr_d;
    rr_i_n           = rr_i;
    wcnt_n           = wcnt;
    bus.iwait        = '1;
    bus.iload        = '0;
    bus.dwait        = '1;
    bus.dload        = '0;
    bus.ccwait       = '0;
    bus.ccinv        = '0;
    bus.ccsnoopaddr  = '0;
    bus.ramREN       = 1'b0;
    bus.ramWEN       = 1'b0;
    bus.ramaddr      = '0;
    bus.ramstore     = '0;

    case (state)
      IDLE: begin
        if (|bus.dWEN) begin
          state_n = WB;
          gnt_n   = rr_pick(bus.dWEN, rr_d);
        end else if (|bus.cctrans) begin
          state_n = SNOOP;
          gnt_n   = rr_pick(bus.cctrans, rr_d);
        end else if (|bus.iREN) begin
          state_n = IFETCH;
          gnt_n   = rr_pick(bus.iREN, rr_i);
        end
      end
      WB: begin
        bus.ramWEN     = 1'b1;
        bus.ramaddr    = bus.daddr[gnt];
        bus.ramstore   = bus.dstore[gnt];
        bus.dwait[gnt] = !access;
      end
      IFETCH: begin
        bus.ramREN     = 1'b1;
        bus.ramaddr    = bus.iaddr[gnt];
        bus.iload[gnt] = bus.ramload;
        bus.iwait[gnt] = !access;
        if (access) begin
          state_n = IDLE;
          rr_i_n  = rr_next(gnt);
        end
      end
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != gnt) begin
            bus.ccsnoopaddr[IW'(j)] = req_addr;
            bus.ccwait[IW'(j)]      = 1'b1;
            bus.ccinv[IW'(j)]       = bus.ccwrite[gnt];
          end
        end
        if (all_resp) begin
          if (hit) begin
            state_n = C2C;
            resp_n  = resp_sel;
          end else if (bus.dREN[gnt]) begin
            state_n = RAMLD;
          end else begin
            state_n = IDLE;
            rr_d_n  = rr_next(gnt);
          end
        end
      end
      C2C: begin
        bus.ccwait[resp]      = 1'b1;
        bus.ccsnoopaddr[resp] = req_addr;
        bus.ramWEN            = 1'b1;
        bus.ramaddr           = bus.daddr[resp];
        bus.ramstore          = bus.dstore[resp];
        bus.dload[gnt]        = bus.dstore[resp];
        bus.dwait[gnt]        = !access;
        bus.dwait[resp]       = !access;
      end
      RAMLD: begin
        bus.ramREN     = 1'b1;
        bus.ramaddr    = bus.daddr[gnt];
        bus.dload[gnt] = bus.ramload;
        bus.dwait[gnt] = !access;
      end
      default: state_n = IDLE;
    endcase

    // Block-sized transfers finish on the last accepted word.
    if ((state == WB || state == C2C || state == RAMLD) && access) begin
      if (last_word) begin
        state_n = IDLE;
        wcnt_n  = '0;
        rr_d_n  = rr_next(gnt);
      end else begin
        wcnt_n = wcnt + CW'(1);
      end
    end
  end

`ifdef COHERENCE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c2c_cnt   <= '0;
      ramld_cnt <= '0;
      wb_cnt    <= '0;
    end else begin
      if (state == SNOOP && state_n == C2C && c2c_cnt != '1) c2c_cnt <= c2c_cnt + 32'd1;
      if (state == SNOOP && state_n == RAMLD && ramld_cnt != '1) ramld_cnt <= ramld_cnt + 32'd1;
      if (state == IDLE && state_n == WB && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif
endmodule
